// File: rtl/ikaopll_pkg.sv
// Shared definitions for the OPLL register-write scheduler: FSM encoding,
// default bus timing and tick-counter helpers.
package ikaopll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR_WR   = 3'd1,
        ST_ADDR_WAIT = 3'd2,
        ST_DATA_WR   = 3'd3,
        ST_DATA_WAIT = 3'd4
    } wr_state_t;

    localparam int DEF_WR_LEN    = 2;
    localparam int DEF_ADDR_WAIT = 6;
    localparam int DEF_DATA_WAIT = 42;

    localparam int CNT_W = 6;

    // A phase lasting n ticks starts its down-counter at n-1 and leaves on 0.
    function automatic logic [CNT_W-1:0] ticks_to_cnt(input int ticks);
        return CNT_W'(ticks - 1);
    endfunction

endpackage

// File: rtl/ikaopll_rrarb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer remembers who was
// served last and only moves when a grant is actually taken.
module ikaopll_rrarb2 (
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic       i_update,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_last_b;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_last_b ? 2'b01 : 2'b10;
        end
    end

    // Reset points at B so that A takes the first tie.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_last_b <= 1'b1;
        end else if (i_update) begin
            r_last_b <= o_gnt[1];
        end
    end

endmodule

// File: rtl/ikaopll_wrsched.sv
// Serialises register writes from two requesters into OPLL address/data bus
// cycles, pacing them with phi1 ticks so the chip has time to absorb each write.
module ikaopll_wrsched
    import ikaopll_pkg::*;
#(
    parameter int WR_LEN    = DEF_WR_LEN,
    parameter int ADDR_WAIT = DEF_ADDR_WAIT,
    parameter int DATA_WAIT = DEF_DATA_WAIT
) (
    input  logic       i_EMUCLK,
    input  logic       i_RST,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_A_VALID,
    input  logic [7:0] i_A_REG,
    input  logic [7:0] i_A_DATA,
    input  logic       i_B_VALID,
    input  logic [7:0] i_B_REG,
    input  logic [7:0] i_B_DATA,
    output logic       o_A_READY,
    output logic       o_B_READY,
    output logic       o_CS_n,
    output logic       o_WR_n,
    output logic       o_A0,
    output logic [7:0] o_D,
    output logic       o_BUSY,
    output logic       o_GNT_B
);

    localparam logic [CNT_W-1:0] C_WR_LD   = ticks_to_cnt(WR_LEN);
    localparam logic [CNT_W-1:0] C_AWAIT_LD = ticks_to_cnt(ADDR_WAIT);
    localparam logic [CNT_W-1:0] C_DWAIT_LD = ticks_to_cnt(DATA_WAIT);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    wr_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_data;
    logic             r_cs_n;
    logic             r_wr_n;
    logic             r_a0;
    logic [7:0]       r_d;
    logic             r_busy;
    logic             r_gnt_b;

    logic       w_en;
    logic       w_idle;
    logic [1:0] w_gnt;
    logic       w_accept;
    logic       w_cnt_zero;

    assign w_en       = ~i_phi1_NCEN_n;
    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = w_idle & w_en & (|w_gnt);
    assign w_cnt_zero = (r_cnt == '0);

    ikaopll_rrarb2 u_arb (
        .i_clk    (i_EMUCLK),
        .i_srst   (i_RST),
        .i_update (w_accept),
        .i_req    ({i_B_VALID, i_A_VALID}),
        .o_gnt    (w_gnt)
    );

    // READY is the handshake itself, so it must follow the enable combinationally.
    assign o_A_READY = w_idle & w_en & w_gnt[0];
    assign o_B_READY = w_idle & w_en & w_gnt[1];

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_data  <= 8'h00;
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_a0    <= 1'b0;
            r_d     <= 8'h00;
            r_busy  <= 1'b0;
            r_gnt_b <= 1'b0;
        end else if (w_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_d     <= w_gnt[1] ? i_B_REG  : i_A_REG;
                        r_data  <= w_gnt[1] ? i_B_DATA : i_A_DATA;
                        r_gnt_b <= w_gnt[1];
                        r_cnt   <= C_WR_LD;
                        r_state <= ST_ADDR_WR;
                        r_cs_n  <= 1'b0;
                        r_wr_n  <= 1'b0;
                        r_a0    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ADDR_WR: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= C_AWAIT_LD;
                        r_state <= ST_ADDR_WAIT;
                        r_cs_n  <= 1'b1;
                        r_wr_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                ST_ADDR_WAIT: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= C_WR_LD;
                        r_state <= ST_DATA_WR;
                        r_cs_n  <= 1'b0;
                        r_wr_n  <= 1'b0;
                        r_a0    <= 1'b1;
                        r_d     <= r_data;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                ST_DATA_WR: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= C_DWAIT_LD;
                        r_state <= ST_DATA_WAIT;
                        r_cs_n  <= 1'b1;
                        r_wr_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                ST_DATA_WAIT: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_IDLE;
                        r_a0    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_cs_n  <= 1'b1;
                    r_wr_n  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_CS_n  = r_cs_n;
    assign o_WR_n  = r_wr_n;
    assign o_A0    = r_a0;
    assign o_D     = r_d;
    assign o_BUSY  = r_busy;
    assign o_GNT_B = r_gnt_b;

endmodule

// File: tb/tb_ikaopll_wrsched.sv
// Directed bench for the OPLL write scheduler: phase tables per transaction
// plus hand-written sequences for arbitration, reset abort and enable stalls.
module tb_ikaopll_wrsched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ncen_n = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [7:0] a_reg = 8'h00, a_data = 8'h00, b_reg = 8'h00, b_data = 8'h00;
    logic       a_ready, b_ready, cs_n, wr_n, a0, busy, gnt_b;
    logic [7:0] d;

    int n_checks = 0;
    int n_errors = 0;
    logic rdy_a_s, rdy_b_s;

    always #5 clk = ~clk;

    ikaopll_wrsched dut (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phi1_NCEN_n (ncen_n),
        .i_A_VALID     (a_valid),
        .i_A_REG       (a_reg),
        .i_A_DATA      (a_data),
        .i_B_VALID     (b_valid),
        .i_B_REG       (b_reg),
        .i_B_DATA      (b_data),
        .o_A_READY     (a_ready),
        .o_B_READY     (b_ready),
        .o_CS_n        (cs_n),
        .o_WR_n        (wr_n),
        .o_A0          (a0),
        .o_D           (d),
        .o_BUSY        (busy),
        .o_GNT_B       (gnt_b)
    );

    typedef struct {
        int         ticks;
        logic       cs_n;
        logic       wr_n;
        logic       a0;
        logic       busy;
        logic [7:0] d;
        logic       chk_bus;
    } phase_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One phi1 tick: NCEN low for one EMUCLK edge, high for the next.
    task automatic tick();
        @(negedge clk);
        ncen_n = 1'b0;
        #1;
        rdy_a_s = a_ready;
        rdy_b_s = b_ready;
        @(posedge clk);
        @(negedge clk);
        ncen_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_bus"}, {20'd0, cs_n, wr_n, a0, busy, gnt_b, d}, {20'd0, 5'b11000, 8'h00});
        chk({name, "_ready"}, {30'd0, a_ready, b_ready}, 32'd0);
    endtask

    // Full transaction from one requester, checked tick by tick against a phase table.
    task automatic run_txn(input logic side_b, input logic [7:0] rg, input logic [7:0] dt,
                           input logic corrupt);
        phase_t ph[5];
        bit first;
        ph[0] = '{2,  1'b0, 1'b0, 1'b0, 1'b1, rg, 1'b1};
        ph[1] = '{6,  1'b1, 1'b1, 1'b0, 1'b1, rg, 1'b1};
        ph[2] = '{2,  1'b0, 1'b0, 1'b1, 1'b1, dt, 1'b1};
        ph[3] = '{42, 1'b1, 1'b1, 1'b1, 1'b1, dt, 1'b1};
        ph[4] = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        if (side_b) begin
            b_valid = 1'b1; b_reg = rg; b_data = dt;
        end else begin
            a_valid = 1'b1; a_reg = rg; a_data = dt;
        end
        #1;
        chk("ready_while_ncen_high", {30'd0, a_ready, b_ready}, 32'd0);
        tick();
        chk("accept_ready", {30'd0, rdy_a_s, rdy_b_s}, side_b ? 32'd1 : 32'd2);
        chk("accept_gnt_b", {31'd0, gnt_b}, {31'd0, side_b});
        if (corrupt) begin
            b_reg = 8'hFF; b_data = 8'hFF; a_reg = 8'hFF; a_data = 8'hFF;
        end else begin
            a_valid = 1'b0; b_valid = 1'b0;
        end
        first = 1'b1;
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < ph[p].ticks; k++) begin
                if (!first) begin
                    tick();
                    if (p == 0) chk("ready_low_busy", {30'd0, rdy_a_s, rdy_b_s}, 32'd0);
                end
                first = 1'b0;
                chk($sformatf("phase%0d_tick%0d_ctrl", p, k), {29'd0, cs_n, wr_n, busy},
                    {29'd0, ph[p].cs_n, ph[p].wr_n, ph[p].busy});
                if (ph[p].chk_bus)
                    chk($sformatf("phase%0d_tick%0d_bus", p, k), {23'd0, a0, d},
                        {23'd0, ph[p].a0, ph[p].d});
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        int n, last_t, n_acc;
        logic exp_b;

        do_reset();
        chk_reset_outputs("reset");

        // A-only write, then B write whose inputs are trashed right after acceptance.
        run_txn(1'b0, 8'h10, 8'h5A, 1'b0);
        run_txn(1'b1, 8'h20, 8'h33, 1'b1);

        // Enable stall in the middle of the address wait.
        do_reset();
        a_valid = 1'b1; a_reg = 8'h44; a_data = 8'h99;
        tick();
        a_valid = 1'b0;
        repeat (4) tick();
        chk("stall_pre", {19'd0, cs_n, wr_n, a0, busy, gnt_b, d}, {19'd0, 5'b11010, 8'h44});
        repeat (100) @(posedge clk);
        #1;
        chk("stall_post", {19'd0, cs_n, wr_n, a0, busy, gnt_b, d}, {19'd0, 5'b11010, 8'h44});
        n = 0;
        for (int t = 0; t < 20 && cs_n; t++) begin
            tick();
            n++;
        end
        chk("stall_ticks_to_data_wr", n, 4);
        chk("stall_data_bus", {23'd0, a0, d}, {23'd0, 1'b1, 8'h99});
        n = 0;
        for (int t = 0; t < 100 && busy; t++) begin
            tick();
            n++;
        end
        chk("stall_ticks_to_idle", n, 44);

        // Reset abort during the data wait; A must then win the next tie.
        do_reset();
        a_valid = 1'b1; a_reg = 8'h55; a_data = 8'h66;
        tick();
        a_valid = 1'b0;
        repeat (20) tick();
        chk("abort_pre", {30'd0, busy, a0}, 32'd3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("abort_reset");
        @(negedge clk);
        rst = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        tick();
        chk("abort_tie_winner", {30'd0, rdy_a_s, rdy_b_s}, 32'd2);
        chk("abort_tie_gnt_b", {31'd0, gnt_b}, 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;

        // Both requesters held valid from reset: alternating grants, 53-tick spacing.
        do_reset();
        a_valid = 1'b1; a_reg = 8'h01; a_data = 8'h02;
        b_valid = 1'b1; b_reg = 8'h03; b_data = 8'h04;
        last_t = 0; n_acc = 0; exp_b = 1'b0;
        for (int t = 0; t < 4 * 53 + 10 && n_acc < 4; t++) begin
            tick();
            if (rdy_a_s || rdy_b_s) begin
                chk($sformatf("rr_winner%0d", n_acc), {30'd0, rdy_a_s, rdy_b_s},
                    exp_b ? 32'd1 : 32'd2);
                chk($sformatf("rr_gnt_b%0d", n_acc), {31'd0, gnt_b}, {31'd0, exp_b});
                chk($sformatf("rr_bus%0d", n_acc), {24'd0, d}, exp_b ? 32'h03 : 32'h01);
                if (n_acc > 0) chk($sformatf("rr_spacing%0d", n_acc), t - last_t, 53);
                last_t = t;
                n_acc++;
                exp_b = ~exp_b;
            end
        end
        chk("rr_accepts", n_acc, 4);
        a_valid = 1'b0; b_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
